// File: rtl/aes_nist_decrypt.sv
// Iterative AES-128 inverse cipher in NIST byte order, one round per clock.
// Round keys are expanded on demand and reused when the same key arrives again.
module aes_nist_decrypt #(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [127:0] i_Key,
  input  logic [127:0] i_Cipher_Text,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [127:0] o_Plain_Text
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;
  state_t state, state_next;

  logic             ready, cache_ok, accept, hit;
  logic [3:0]       cnt, kidx;
  logic [127:0]     ct, plain, key_prev, key_next;
  logic [127:0]     rk [0:10];
  logic [0:15][7:0] blk, isb, ark, imc;
  logic [31:0]      rot, sub, temp, nk0, nk1, nk2, nk3;
  logic [7:0]       rcon;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] a2, a4, a8;
    a2 = xt(a);
    a4 = xt(a2);
    a8 = xt(a4);
    return (m[3] ? a8 : 8'h00) ^ (m[2] ? a4 : 8'h00) ^ (m[1] ? a2 : 8'h00) ^ (m[0] ? a : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm(a0, 4'd14) ^ gm(a1, 4'd11) ^ gm(a2, 4'd13) ^ gm(a3, 4'd9),
            gm(a0, 4'd9)  ^ gm(a1, 4'd14) ^ gm(a2, 4'd11) ^ gm(a3, 4'd13),
            gm(a0, 4'd13) ^ gm(a1, 4'd9)  ^ gm(a2, 4'd14) ^ gm(a3, 4'd11),
            gm(a0, 4'd11) ^ gm(a1, 4'd13) ^ gm(a2, 4'd9)  ^ gm(a3, 4'd14)};
  endfunction

  // Forward key schedule: rk[cnt] is derived from rk[cnt-1]
  assign kidx     = cnt - 4'd1;
  assign key_prev = rk[kidx];
  assign rot      = {key_prev[23:0], key_prev[31:24]};

  always_comb begin
    rcon = 8'h00;
    case (cnt)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sub
      assign sub[31-8*gi -: 8] = SBOX[rot[31-8*gi -: 8]];
    end
    // InvShiftRows folded into the S-box addressing: row r rotates right by r
    for (gi = 0; gi < 16; gi++) begin : g_inv
      assign isb[gi] = INV_SBOX[blk[4*(((gi/4) + 4 - (gi%4)) % 4) + (gi%4)]];
    end
    for (gi = 0; gi < 4; gi++) begin : g_mix
      assign imc[4*gi +: 4] = inv_mix(ark[4*gi +: 4]);
    end
  endgenerate

  assign temp     = sub ^ {rcon, 24'h000000};
  assign nk0      = key_prev[127:96] ^ temp;
  assign nk1      = key_prev[95:64] ^ nk0;
  assign nk2      = key_prev[63:32] ^ nk1;
  assign nk3      = key_prev[31:0] ^ nk2;
  assign key_next = {nk0, nk1, nk2, nk3};

  assign ark = isb ^ rk[cnt];
  assign hit = KEY_CACHE && cache_ok && (i_Key == rk[0]);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (i_Valid && ready) begin
          accept     = 1'b1;
          state_next = hit ? ROUND : KEYEXP;
        end
      end
      KEYEXP:  if (cnt == 4'd10) state_next = ROUND;
      ROUND:   if (cnt == 4'd0) state_next = DONE;
      DONE:    if (i_Ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready    <= 1'b0;
      cache_ok <= 1'b0;
      cnt      <= 4'd0;
      plain    <= '0;
    end else begin
      ready <= (state_next == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            ct    <= i_Cipher_Text;
            rk[0] <= i_Key;
            if (hit) begin
              blk <= i_Cipher_Text ^ rk[10];
              cnt <= 4'd9;
            end else begin
              cache_ok <= 1'b0;
              cnt      <= 4'd1;
            end
          end
        end
        KEYEXP: begin
          rk[cnt] <= key_next;
          if (cnt == 4'd10) begin
            blk      <= ct ^ key_next;
            cache_ok <= 1'b1;
            cnt      <= 4'd9;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          if (cnt == 4'd0) begin
            blk   <= ark;
            plain <= ark;
          end else begin
            blk <= imc;
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Ready      = ready;
  assign o_Valid      = (state == DONE);
  assign o_Plain_Text = plain;
endmodule

// File: tb/tb_aes_nist_decrypt.sv
// Scoreboarded bench for aes_nist_decrypt: known answers, cache hits, backpressure,
// mid-round reset and a loopback against a behavioural AES-128 encryptor.
module tb_aes_nist_decrypt;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, i_valid, o_ready, o_valid, i_ready;
  logic [127:0] key, ct, pt_out;
  logic         nc_valid, nc_ready, nc_out_valid;
  logic [127:0] nc_key, nc_ct, nc_pt;

  aes_nist_decrypt #(.KEY_CACHE(1'b1)) dut (
    .clk(clk), .rst(rst), .i_Valid(i_valid), .o_Ready(o_ready), .i_Key(key),
    .i_Cipher_Text(ct), .o_Valid(o_valid), .i_Ready(i_ready), .o_Plain_Text(pt_out));

  aes_nist_decrypt #(.KEY_CACHE(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .i_Valid(nc_valid), .o_Ready(nc_ready), .i_Key(nc_key),
    .i_Cipher_Text(nc_ct), .o_Valid(nc_out_valid), .i_Ready(1'b1), .o_Plain_Text(nc_pt));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
  } exp_t;
  exp_t sb_q[$];

  logic         cache_ok_m = 1'b0;
  logic [127:0] cache_key_m = '0;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k_in, input logic [127:0] p);
    logic [0:15][7:0] s, t;
    logic [127:0]     k;
    logic [31:0]      w;
    logic [7:0]       rc, a0, a1, a2, a3;
    k  = k_in;
    s  = p ^ k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w = {k[23:0], k[31:24]};
      w = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]} ^ {rc, 24'h0};
      k[127:96] = k[127:96] ^ w;
      k[95:64]  = k[95:64] ^ k[127:96];
      k[63:32]  = k[63:32] ^ k[95:64];
      k[31:0]   = k[31:0] ^ k[63:32];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) t[i] = SBOX[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        s = t;
      end
      s = s ^ k;
    end
    return s;
  endfunction

  // Each rising o_Valid must match the oldest outstanding request
  logic prev_v = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (o_valid && !prev_v) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_valid", {127'd0, o_valid}, 128'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("plain", pt_out, mon_e.pt);
        check_eq("latency", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
      end
    end
    prev_v <= o_valid;
  end

  // Called at a falling edge; returns at the falling edge after the accept edge
  task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    int   n = 0;
    exp_t e;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", {127'd0, o_ready}, 128'd1);
    e.pt  = p;
    e.lat = (cache_ok_m && k == cache_key_m) ? 10 : 20;
    e.acc = cyc + 1;
    sb_q.push_back(e);
    cache_ok_m  = 1'b1;
    cache_key_m = k;
    key     = k;
    ct      = c;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    key     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 128'(sb_q.size()), 128'd0);
  endtask

  initial begin
    logic [127:0] k, p, prev_k;
    int n, acc;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; key = '0; ct = '0;
    nc_valid = 1'b0; nc_key = '0; nc_ct = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {127'd0, o_ready}, 128'd0);
    check_eq("rst_valid", {127'd0, o_valid}, 128'd0);
    check_eq("rst_plain", pt_out, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", {127'd0, o_ready}, 128'd1);

    // Known answers: expand, expand, cache hit, new key
    send(C1_KEY, C1_CT, C1_PT); drain();
    send(B_KEY, B_CT, B_PT);    drain();
    send(B_KEY, B_CT, B_PT);    drain();
    send(C1_KEY, C1_CT, C1_PT); drain();

    // Backpressure with ignored requests while busy
    i_ready = 1'b0;
    send(B_KEY, B_CT, B_PT);
    n = 0;
    while (!o_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 15; i++) begin
      check_eq("bp_valid", {127'd0, o_valid}, 128'd1);
      check_eq("bp_plain", pt_out, B_PT);
      check_eq("bp_ready", {127'd0, o_ready}, 128'd0);
      i_valid = 1'b1;
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", {127'd0, o_ready}, 128'd1);
    check_eq("bp_release_valid", {127'd0, o_valid}, 128'd0);
    drain();

    // Reset during ROUND discards the block and the key cache
    send(C1_KEY, C1_CT, C1_PT);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_valid", {127'd0, o_valid}, 128'd0);
    check_eq("abort_plain", pt_out, 128'd0);
    rst = 1'b0;
    sb_q.delete();
    cache_ok_m = 1'b0;
    @(negedge clk);
    check_eq("abort_ready", {127'd0, o_ready}, 128'd1);
    send(B_KEY, B_CT, B_PT); drain();

    // Loopback against the behavioural encryptor, with occasional key reuse
    prev_k = B_KEY;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(7) == 0) k = prev_k;
      else k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      send(k, aes_enc(k, p), p);
      prev_k = k;
    end
    drain();

    // Without the cache every request pays for expansion
    for (int i = 0; i < 2; i++) begin
      n = 0;
      while (!nc_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      check_eq("nc_ready", {127'd0, nc_ready}, 128'd1);
      nc_key = B_KEY; nc_ct = B_CT; nc_valid = 1'b1;
      acc = cyc + 1;
      @(negedge clk);
      nc_valid = 1'b0;
      n = 0;
      while (!nc_out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      check_eq("nc_latency", 128'(cyc - acc), 128'd20);
      check_eq("nc_plain", nc_pt, B_PT);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
